// File: rtl/l2_req_scheduler.sv
// l2_req_scheduler: round-robin arbiter sharing one L2 port between I-cache and D-cache misses.
// Ports: clk/rst_n (async active-low); i_* I-cache request/response; d_* D-cache request/response;
// l2_* registered request to L2 plus its resp/rdata; *_cnt optional performance counters.
// Optional feature: define L2_SCHED_PERF_EN to build the saturating grant/conflict counters,
// otherwise the counter outputs are tied to 0.
module l2_req_scheduler #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              l2_read,
    output logic              l2_write,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic              l2_resp,
    input  logic [LINE_W-1:0] l2_rdata,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt,
    output logic [CNT_W-1:0]  conflict_cnt
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, GAP} state_t;
    state_t state_q, state_d;
    logic last_d_q, last_d_d;
    logic wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic i_req, d_req, grant_i, grant_d, busy;
    always_comb begin
        i_req   = i_read;
        d_req   = d_read | d_write;
        // On a tie the side that did not win last time takes the grant.
        grant_i = (state_q == IDLE) & i_req & (~d_req | last_d_q);
        grant_d = (state_q == IDLE) & d_req & ~grant_i;
        state_d  = state_q;
        last_d_d = last_d_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d  = BUSY_I;
                    addr_d   = i_addr;
                    wr_d     = 1'b0;
                    last_d_d = 1'b0;
                end else if (grant_d) begin
                    state_d  = BUSY_D;
                    addr_d   = d_addr;
                    wr_d     = d_write;
                    wdata_d  = d_wdata;
                    last_d_d = 1'b1;
                end
            end
            BUSY_I, BUSY_D: state_d = l2_resp ? GAP : state_q;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end
    assign busy     = (state_q == BUSY_I) | (state_q == BUSY_D);
    assign l2_read  = busy & ~wr_q;
    assign l2_write = busy & wr_q;
    assign l2_addr  = addr_q;
    assign l2_wdata = wdata_q;
    assign i_resp   = (state_q == BUSY_I) & l2_resp;
    assign d_resp   = (state_q == BUSY_D) & l2_resp;
    assign i_rdata  = l2_rdata;
    assign d_rdata  = l2_rdata;
`ifdef L2_SCHED_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    logic [CNT_W-1:0] icnt_q, icnt_d, dcnt_q, dcnt_d, ccnt_q, ccnt_d;
    logic conflict;
    always_comb begin
        conflict = (state_q == IDLE) & i_req & d_req;
        icnt_d   = (grant_i && ~&icnt_q) ? icnt_q + CNT_ONE : icnt_q;
        dcnt_d   = (grant_d && ~&dcnt_q) ? dcnt_q + CNT_ONE : dcnt_q;
        ccnt_d   = (conflict && ~&ccnt_q) ? ccnt_q + CNT_ONE : ccnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icnt_q <= '0;
            dcnt_q <= '0;
            ccnt_q <= '0;
        end else begin
            icnt_q <= icnt_d;
            dcnt_q <= dcnt_d;
            ccnt_q <= ccnt_d;
        end
    end
    assign i_grant_cnt  = icnt_q;
    assign d_grant_cnt  = dcnt_q;
    assign conflict_cnt = ccnt_q;
`else
    assign i_grant_cnt  = '0;
    assign d_grant_cnt  = '0;
    assign conflict_cnt = '0;
`endif
endmodule

// File: tb/tb_l2_req_scheduler.sv
// tb_l2_req_scheduler: self-checking bench for l2_req_scheduler.
module tb_l2_req_scheduler;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  i_addr = '0, d_addr = '0;
    logic         i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [127:0] d_wdata = '0, l2_rdata = '0;
    logic         l2_resp = 1'b0;
    logic         i_resp, d_resp, l2_read, l2_write;
    logic [127:0] i_rdata, d_rdata, l2_wdata;
    logic [15:0]  l2_addr;
    logic [31:0]  i_grant_cnt, d_grant_cnt, conflict_cnt;

    l2_req_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_read(i_read), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .l2_addr(l2_addr), .l2_read(l2_read), .l2_write(l2_write), .l2_wdata(l2_wdata),
        .l2_resp(l2_resp), .l2_rdata(l2_rdata),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ir, dr, dw;
        logic [15:0] ia, da;
        logic [127:0] wd, rd;
        int lat;
        logic exp_d, exp_wr;
        logic [15:0] exp_addr;
    } vec_t;

    typedef struct {
        logic is_d;
        logic [127:0] rdata;
    } exp_t;

    vec_t tbl[8];
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Returns the number of falling edges until an L2 strobe is seen (capped at 8).
    task automatic wait_grant(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(l2_read | l2_write) && n < 8);
    endtask

    // Called at a falling edge inside BUSY: pulses l2_resp and scores the response.
    task automatic finish_txn(input logic is_d, input logic [127:0] rd);
        exp_t e;
        sb.push_back('{is_d, rd});
        l2_resp  = 1'b1;
        l2_rdata = rd;
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            chk("i_resp", i_resp, !e.is_d);
            chk("d_resp", d_resp, e.is_d);
            chk("rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
        end
        @(negedge clk);
        l2_resp = 1'b0;
        chk("gap_strobe", {l2_read, l2_write}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h1230, 16'h0000, 128'h0, {16{8'hA5}}, 0, 1'b0, 1'b0, 16'h1230};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h4000, 128'h0, {16{8'h3C}}, 1, 1'b1, 1'b0, 16'h4000};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 16'h0ABC, 16'h2468, {4{32'hDEADBEEF}}, {8{16'h1111}}, 2, 1'b0, 1'b0, 16'h0ABC};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 16'h0ABD, 16'h2470, {4{32'hCAFEF00D}}, {8{16'h2222}}, 0, 1'b1, 1'b1, 16'h2470};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 16'h0F00, 16'h0E00, {4{32'h01234567}}, {8{16'h3333}}, 1, 1'b0, 1'b0, 16'h0F00};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0E10, {4{32'h89ABCDEF}}, {8{16'h4444}}, 3, 1'b1, 1'b1, 16'h0E10};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 16'h3330, 16'h4440, 128'h0, {8{16'h5555}}, 0, 1'b0, 1'b0, 16'h3330};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 16'h3334, 16'h4000, 128'h0, {8{16'h6666}}, 1, 1'b1, 1'b0, 16'h4000};

        repeat (2) @(negedge clk);
        chk("rst_strobes", {l2_read, l2_write, i_resp, d_resp}, 4'b0000);
        chk("rst_addr", l2_addr, 16'h0);
        chk("rst_wdata", l2_wdata, 128'h0);
        chk("rst_cnt", {i_grant_cnt, d_grant_cnt, conflict_cnt}, 96'h0);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            i_addr  = tbl[k].ia;
            d_addr  = tbl[k].da;
            d_wdata = tbl[k].wd;
            i_read  = tbl[k].ir;
            d_read  = tbl[k].dr;
            d_write = tbl[k].dw;
            wait_grant(n);
            chk($sformatf("grant_lat%0d", k), n, (k == 0) ? 1 : 2);
            chk($sformatf("op%0d", k), {l2_read, l2_write}, {!tbl[k].exp_wr, tbl[k].exp_wr});
            chk($sformatf("addr%0d", k), l2_addr, tbl[k].exp_addr);
            if (tbl[k].exp_wr) chk($sformatf("wdata%0d", k), l2_wdata, tbl[k].wd);
            // Move every requester input and drop the winner's request: the transaction must hold.
            i_addr  = i_addr ^ 16'h1000;
            d_addr  = d_addr ^ 16'h1000;
            d_wdata = ~d_wdata;
            if (tbl[k].exp_d) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end else begin
                i_read = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("hold_op%0d", k), {l2_read, l2_write}, {!tbl[k].exp_wr, tbl[k].exp_wr});
            chk($sformatf("hold_addr%0d", k), l2_addr, tbl[k].exp_addr);
            if (tbl[k].exp_wr) chk($sformatf("hold_wdata%0d", k), l2_wdata, tbl[k].wd);
            repeat (tbl[k].lat) @(negedge clk);
            finish_txn(tbl[k].exp_d, tbl[k].rd);
            i_read  = 1'b0;
            d_read  = 1'b0;
            d_write = 1'b0;
        end

`ifdef L2_SCHED_PERF_EN
        chk("i_grant_cnt", i_grant_cnt, 32'd4);
        chk("d_grant_cnt", d_grant_cnt, 32'd4);
        chk("conflict_cnt", conflict_cnt, 32'd5);
`else
        chk("i_grant_cnt", i_grant_cnt, 32'd0);
        chk("d_grant_cnt", d_grant_cnt, 32'd0);
        chk("conflict_cnt", conflict_cnt, 32'd0);
`endif

        // Spurious l2_resp while IDLE must produce nothing and leave the FSM in IDLE.
        @(negedge clk);
        l2_resp  = 1'b1;
        l2_rdata = {16{8'hEE}};
        #1;
        chk("spur_resp", {i_resp, d_resp}, 2'b00);
        @(negedge clk);
        l2_resp = 1'b0;
        chk("spur_strobe", {l2_read, l2_write}, 2'b00);
        i_addr = 16'h7770;
        i_read = 1'b1;
        wait_grant(n);
        chk("spur_grant_lat", n, 1);
        chk("spur_grant_addr", l2_addr, 16'h7770);

        // Asynchronous reset in the middle of BUSY_I, then a pending D read is served.
        i_read = 1'b0;
        d_addr = 16'h2220;
        d_read = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_strobes", {l2_read, l2_write, i_resp, d_resp}, 4'b0000);
        chk("mid_rst_addr", l2_addr, 16'h0);
        chk("mid_rst_cnt", {i_grant_cnt, d_grant_cnt, conflict_cnt}, 96'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_grant(n);
        chk("post_rst_lat", n, 1);
        chk("post_rst_op", {l2_read, l2_write}, 2'b10);
        chk("post_rst_addr", l2_addr, 16'h2220);
        d_read = 1'b0;
        finish_txn(1'b1, {8{16'h7777}});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
